// File: rtl/apb_gpio_slave.sv
// APB slave exposing a GPIO block (output data, direction, synchronised input, rising-edge IRQ)
// with a programmable number of access-phase wait states.
//
// state  | meaning
// IDLE   | no transfer in progress; a PSEL&PENABLE cycle here is access cycle 1 (cnt 0)
// ACCESS | inserting wait states; cnt holds the index of the current access cycle
module apb_gpio_slave #(
  parameter int GPIO_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               access_cyc;
  logic               ready;

  logic [GPIO_W-1:0]  dout_q, dir_q, irq_en_q, irq_stat_q, irq_stat_d;
  logic [GPIO_W-1:0]  sync1_q, sync2_q, hist_q;
  logic [GPIO_W-1:0]  rise, w1c_mask, wdata;
  logic [7:0]         offset;
  logic               sel_dout, sel_dir, sel_din, sel_en, sel_stat;
  logic               mapped, xfer_err, do_write;
  logic [31:0]        rd_word;
  logic               unused_bits;

  assign access_cyc = PSEL & PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first access cycle is handled from IDLE, so ACCESS starts counting at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (access_cyc) begin
          if (WS == 4'd0) begin
            ready = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 4'd1;
          end
        end
      end
      ACCESS: begin
        if (!access_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WS) begin
          ready   = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Suppressed while reset is asserted so an aborted transfer never reports completion.
  assign PREADY = ready & ~PRESET;

  assign offset   = PADDR[7:0];
  assign sel_dout = (offset == 8'h00);
  assign sel_dir  = (offset == 8'h04);
  assign sel_din  = (offset == 8'h08);
  assign sel_en   = (offset == 8'h0C);
  assign sel_stat = (offset == 8'h10);
  assign mapped   = sel_dout | sel_dir | sel_din | sel_en | sel_stat;
  assign xfer_err = ~mapped | (PWRITE & sel_din);
  assign do_write = PREADY & PWRITE & ~xfer_err;
  assign wdata    = PWDATA[GPIO_W-1:0];

  always_comb begin
    rd_word = 32'd0;
    case (1'b1)
      sel_dout: rd_word[GPIO_W-1:0] = dout_q;
      sel_dir:  rd_word[GPIO_W-1:0] = dir_q;
      sel_din:  rd_word[GPIO_W-1:0] = sync2_q;
      sel_en:   rd_word[GPIO_W-1:0] = irq_en_q;
      sel_stat: rd_word[GPIO_W-1:0] = irq_stat_q;
      default:  rd_word = 32'd0;
    endcase
  end

  assign PRDATA  = (PREADY & ~PWRITE & ~xfer_err) ? rd_word : 32'd0;
  assign PSLVERR = PREADY & xfer_err;

  // A rise in the same cycle as a W1C clear keeps the status bit set.
  assign rise       = sync2_q & ~hist_q;
  assign w1c_mask   = (do_write & sel_stat) ? wdata : '0;
  assign irq_stat_d = (irq_stat_q & ~w1c_mask) | rise;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      dout_q     <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      irq        <= 1'b0;
    end else begin
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      irq_stat_q <= irq_stat_d;
      irq        <= |(irq_stat_q & irq_en_q);
      if (do_write && sel_dout) dout_q   <= wdata;
      if (do_write && sel_dir)  dir_q    <= wdata;
      if (do_write && sel_en)   irq_en_q <= wdata;
    end
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;

  assign unused_bits = ^{PADDR[31:8], PWDATA};

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Bench for apb_gpio_slave: three instances (0, 1 and 3 wait states) share the bus except PSEL;
// instance 0 is checked against a register-level model under directed and random traffic.
module tb_apb_gpio_slave;
  localparam int GW = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [2:0]    psel = 3'b000;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [31:0]   PADDR = 32'd0;
  logic [31:0]   PWDATA = 32'd0;
  logic [GW-1:0] gpio_in = '0;

  logic [31:0]   prdata [3];
  logic          pready [3];
  logic          pslverr[3];
  logic [GW-1:0] gout   [3];
  logic [GW-1:0] goe    [3];
  logic          irq    [3];

  int total = 0;
  int bad   = 0;
  int ws_of[3] = '{1, 0, 3};

  logic [31:0] m_dout = 0, m_dir = 0, m_en = 0, m_stat = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio_slave #(.GPIO_W(GW), .WAIT_STATES(1)) u0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .gpio_in(gpio_in), .gpio_out(gout[0]), .gpio_oe(goe[0]), .irq(irq[0]));
  apb_gpio_slave #(.GPIO_W(GW), .WAIT_STATES(0)) u1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .gpio_in(gpio_in), .gpio_out(gout[1]), .gpio_oe(goe[1]), .irq(irq[1]));
  apb_gpio_slave #(.GPIO_W(GW), .WAIT_STATES(3)) u2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .gpio_in(gpio_in), .gpio_out(gout[2]), .gpio_oe(goe[2]), .irq(irq[2]));

  // Register-level reference for instance 0.
  function automatic logic m_err(input logic wr, input logic [7:0] off);
    return !(off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10}) || (wr && off == 8'h08);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return m_dout;
      8'h04:   return m_dir;
      8'h08:   return {24'd0, gpio_in};
      8'h0C:   return m_en;
      8'h10:   return m_stat;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] off, input logic [31:0] data);
    if (!m_err(1'b1, off)) begin
      case (off)
        8'h00:   m_dout = data & MASK;
        8'h04:   m_dir  = data & MASK;
        8'h0C:   m_en   = data & MASK;
        8'h10:   m_stat = m_stat & ~data;
        default: ;
      endcase
    end
  endtask

  task automatic set_gpio(input logic [GW-1:0] v);
    m_stat  = m_stat | {24'd0, v & ~gpio_in};
    gpio_in = v;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic err, output int ncyc);
    logic done;
    done = 1'b0; rd = 32'd0; err = 1'b0; ncyc = 0;
    psel = 3'b001 << d; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      ncyc++;
      if (pready[d] === 1'b1) begin
        rd = prdata[d]; err = pslverr[d]; done = 1'b1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL xfer_timeout dut=%0d addr=%h: no PREADY, want PREADY within 40 cycles", d, addr);
    end
    @(posedge PCLK); #1 psel = 3'b000; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({prdata[d], pready[d], pslverr[d], gout[d], goe[d], irq[d]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut=%0d got prdata=%h pready=%b pslverr=%b out=%h oe=%h irq=%b want all 0",
                 d, prdata[d], pready[d], pslverr[d], gout[d], goe[d], irq[d]);
      end
    end
    @(posedge PCLK); #1 PRESET = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int n;
    xfer(0, 1'b1, 32'h0, 32'h0000_00A5, rd, err, n);
    m_write(8'h00, 32'h0000_00A5);
    total++;
    if (n !== 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", n); end
    @(negedge PCLK);
    total++;
    if (gout[0] !== 8'hA5) begin bad++; $display("FAIL basic_gpio_out got=%h want=a5", gout[0]); end
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 32'h0, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'hA5 || err !== 1'b0) begin
      bad++; $display("FAIL basic_read got=%h err=%b want=000000a5 err=0", rd, err);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, wd; logic err; int n;
    for (int d = 1; d < 3; d++) begin
      wd = $urandom;
      xfer(d, 1'b1, 32'h4, wd, rd, err, n);
      total++;
      if (n !== ws_of[d] + 1) begin
        bad++; $display("FAIL ws_latency dut=%0d got=%0d want=%0d", d, n, ws_of[d] + 1);
      end
      @(negedge PCLK);
      total++;
      if (pready[d] !== 1'b0) begin bad++; $display("FAIL ws_pready_width dut=%0d got=%b want=0", d, pready[d]); end
      @(posedge PCLK); #1;
      xfer(d, 1'b0, 32'h4, 32'h0, rd, err, n);
      total++;
      if (rd !== (wd & MASK) || n !== ws_of[d] + 1) begin
        bad++; $display("FAIL ws_read dut=%0d got=%h n=%0d want=%h n=%0d", d, rd, n, wd & MASK, ws_of[d] + 1);
      end
    end
  endtask

  task automatic test_din();
    logic [31:0] rd; logic err; int n;
    set_gpio(8'h3C);
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL din_early got=%h want=00000000", rd); end
    repeat (3) @(posedge PCLK); #1;
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'h3C) begin bad++; $display("FAIL din_settled_dut1 got=%h want=0000003c", rd); end
    xfer(0, 1'b0, 32'h8, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'h3C) begin bad++; $display("FAIL din_settled_dut0 got=%h want=0000003c", rd); end
    xfer(0, 1'b1, 32'h10, 32'hFF, rd, err, n);
    m_write(8'h10, 32'hFF);
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err; int n;
    xfer(0, 1'b1, 32'hC, 32'h01, rd, err, n);
    m_write(8'h0C, 32'h01);
    set_gpio(8'h3D);
    repeat (5) @(posedge PCLK); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'h01) begin bad++; $display("FAIL irq_stat_set got=%h want=00000001", rd); end
    @(negedge PCLK);
    total++;
    if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_asserted got=%b want=1", irq[0]); end
    @(posedge PCLK); #1;
    xfer(0, 1'b1, 32'h10, 32'h01, rd, err, n);
    m_write(8'h10, 32'h01);
    repeat (2) @(negedge PCLK);
    total++;
    if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b want=0", irq[0]); end
    @(posedge PCLK); #1;
    set_gpio(8'h3C);
    repeat (5) @(posedge PCLK); #1;
    // the rise reaches IRQ_STAT on the same edge as the W1C commit, so the bit must survive
    set_gpio(8'h3D);
    xfer(0, 1'b1, 32'h10, 32'h01, rd, err, n);
    repeat (3) @(posedge PCLK); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, rd, err, n);
    total++;
    if (rd !== 32'h01) begin bad++; $display("FAIL irq_w1c_vs_rise got=%h want=00000001", rd); end
    @(negedge PCLK);
    total++;
    if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_after_race got=%b want=1", irq[0]); end
    @(posedge PCLK); #1;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int n;
    xfer(0, 1'b0, 32'h14, 32'h0, rd, err, n);
    total++;
    if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_unmapped_read got err=%b rd=%h want err=1 rd=0", err, rd); end
    xfer(0, 1'b1, 32'h8, 32'hFF, rd, err, n);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_din_write got=%b want=1", err); end
    xfer(0, 1'b1, 32'h1, 32'h5A, rd, err, n);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_unaligned got=%b want=1", err); end
    xfer(0, 1'b0, 32'h1234_5600, 32'h0, rd, err, n);
    total++;
    if (err !== 1'b0 || rd !== m_dout) begin
      bad++; $display("FAIL err_dout_unchanged got=%h err=%b want=%h err=0", rd, err, m_dout);
    end
    xfer(0, 1'b0, 32'h8, 32'h0, rd, err, n);
    total++;
    if (err !== 1'b0 || rd !== m_read(8'h08)) begin
      bad++; $display("FAIL err_din_unchanged got=%h err=%b want=%h err=0", rd, err, m_read(8'h08));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1, d0, d1, rd; logic err; int n0, n1, n2, n3;
    d0 = $urandom; d1 = $urandom;
    xfer(0, 1'b1, 32'h0, d0, rd, err, n0);
    xfer(0, 1'b1, 32'h4, d1, rd, err, n1);
    xfer(0, 1'b0, 32'h0, 32'h0, rd0, err, n2);
    xfer(0, 1'b0, 32'h4, 32'h0, rd1, err, n3);
    m_write(8'h00, d0); m_write(8'h04, d1);
    total++;
    if (rd0 !== m_dout || rd1 !== m_dir) begin
      bad++; $display("FAIL b2b_data got=%h,%h want=%h,%h", rd0, rd1, m_dout, m_dir);
    end
    total++;
    if (n0 !== 2 || n1 !== 2 || n2 !== 2 || n3 !== 2) begin
      bad++; $display("FAIL b2b_latency got=%0d,%0d,%0d,%0d want=2 each", n0, n1, n2, n3);
    end
    @(negedge PCLK);
    total++;
    if ({pready[0], pslverr[0], prdata[0]} !== '0) begin
      bad++; $display("FAIL b2b_idle_outputs got pready=%b pslverr=%b prdata=%h want 0", pready[0], pslverr[0], prdata[0]);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_random();
    logic [7:0]  offs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h02, 8'hFC};
    logic [31:0] hi, data, rd, exp_rd; logic [7:0] off, g; logic wr, err, exp_err; int n;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        g = 8'($urandom);
        set_gpio(g);
        repeat (5) @(posedge PCLK); #1;
      end
      off = offs[$urandom_range(0, 8)];
      hi = $urandom; data = $urandom; wr = 1'($urandom_range(0, 1));
      exp_rd  = wr ? 32'd0 : m_read(off);
      exp_err = m_err(wr, off);
      xfer(0, wr, {hi[31:8], off}, data, rd, err, n);
      if (wr) m_write(off, data);
      total++;
      if (err !== exp_err || rd !== exp_rd) begin
        bad++; $display("FAIL rand_xfer it=%0d wr=%b off=%h got rd=%h err=%b want rd=%h err=%b",
                        it, wr, off, rd, err, exp_rd, exp_err);
      end
      repeat (2) @(negedge PCLK);
      total++;
      if ({gout[0], goe[0], irq[0]} !== {m_dout[7:0], m_dir[7:0], |(m_stat & m_en)}) begin
        bad++; $display("FAIL rand_pins it=%0d got out=%h oe=%h irq=%b want out=%h oe=%h irq=%b",
                        it, gout[0], goe[0], irq[0], m_dout[7:0], m_dir[7:0], |(m_stat & m_en));
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err, seen; int n;
    set_gpio(8'h00);
    repeat (5) @(posedge PCLK); #1;
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h5A;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b1;
    seen = 1'b0;
    @(negedge PCLK); seen = seen | pready[2];
    @(posedge PCLK); #1 PRESET = 1'b0; psel = 3'b000; PENABLE = 1'b0;
    m_dout = 0; m_dir = 0; m_en = 0; m_stat = 0;
    repeat (6) begin @(negedge PCLK); seen = seen | pready[2]; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_pready got=%b want=0", seen); end
    total++;
    if (gout[2] !== 8'h00) begin bad++; $display("FAIL rst_mid_dout got=%h want=00", gout[2]); end
    @(posedge PCLK); #1;
    xfer(2, 1'b1, 32'h0, 32'h33, rd, err, n);
    @(negedge PCLK);
    total++;
    if (n !== 4 || gout[2] !== 8'h33) begin
      bad++; $display("FAIL rst_mid_recover got n=%0d out=%h want n=4 out=33", n, gout[2]);
    end
    @(posedge PCLK); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_din();
    test_irq();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
